// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670-style camera transmitter: FSM states,
// default QVGA timing and the RGB565 colour-bar palette.
package cam_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_VSYNC,
      ST_VFRONT,
      ST_ACTIVE,
      ST_VBACK
   } cam_state_e;

   localparam int H_ACTIVE_DEF    = 320;
   localparam int V_ACTIVE_DEF    = 240;
   localparam int H_BLANK_DEF     = 144;
   localparam int VSYNC_LINES_DEF = 3;
   localparam int V_FRONT_DEF     = 17;
   localparam int V_BACK_DEF      = 10;

   localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
   localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
   localparam logic [15:0] BAR_CYAN    = 16'h07FF;
   localparam logic [15:0] BAR_GREEN   = 16'h07E0;
   localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
   localparam logic [15:0] BAR_RED     = 16'hF800;
   localparam logic [15:0] BAR_BLUE    = 16'h001F;
   localparam logic [15:0] BAR_BLACK   = 16'h0000;

   function automatic logic [15:0] bar_color(input logic [2:0] idx);
      case (idx)
         3'd0:    return BAR_WHITE;
         3'd1:    return BAR_YELLOW;
         3'd2:    return BAR_CYAN;
         3'd3:    return BAR_GREEN;
         3'd4:    return BAR_MAGENTA;
         3'd5:    return BAR_RED;
         3'd6:    return BAR_BLUE;
         default: return BAR_BLACK;
      endcase
   endfunction

endpackage

// File: rtl/cam_colorbar_rom.sv
// Maps a horizontal pixel index to the RGB565 colour of one of eight
// equal-width vertical bars.
module cam_colorbar_rom
   import cam_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int X_W      = 9
) (
   input  logic [X_W-1:0] x_i,
   output logic [15:0]    rgb_o
);

   localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

   logic [X_W-1:0] bar;

   always_comb begin
      bar   = x_i / X_W'(BAR_W);
      rgb_o = (bar > X_W'(7)) ? BAR_BLACK : bar_color(bar[2:0]);
   end

endmodule

// File: rtl/cam_ov7670_tx.sv
// OV7670-style camera transmitter: PCLK = clk/2, VSYNC/HREF framing and an RGB565
// byte stream. Define COLORBAR_EN to replace px_color with an 8-bar test pattern.
module cam_ov7670_tx
   import cam_pkg::*;
#(
   parameter int H_ACTIVE    = H_ACTIVE_DEF,
   parameter int V_ACTIVE    = V_ACTIVE_DEF,
   parameter int H_BLANK     = H_BLANK_DEF,
   parameter int VSYNC_LINES = VSYNC_LINES_DEF,
   parameter int V_FRONT     = V_FRONT_DEF,
   parameter int V_BACK      = V_BACK_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] px_color,
   output logic        cam_pclk,
   output logic        cam_vsync,
   output logic        cam_href,
   output logic [7:0]  cam_px_data,
   output logic        frame_done,
   output logic        busy
);

   localparam int LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
   localparam int BYTE_W    = $clog2(LINE_LEN);
   localparam int MAX_VS_VF = (VSYNC_LINES > V_FRONT) ? VSYNC_LINES : V_FRONT;
   localparam int MAX_VA_VB = (V_ACTIVE > V_BACK) ? V_ACTIVE : V_BACK;
   localparam int MAX_LINES = (MAX_VS_VF > MAX_VA_VB) ? MAX_VS_VF : MAX_VA_VB;
   localparam int LINE_W    = $clog2(MAX_LINES + 1);

   localparam logic [BYTE_W-1:0] LAST_BYTE  = BYTE_W'(LINE_LEN - 1);
   localparam logic [BYTE_W-1:0] HREF_BYTES = BYTE_W'(2 * H_ACTIVE);

   cam_state_e        state_q, state_d;
   logic [BYTE_W-1:0] byte_q, byte_d;
   logic [LINE_W-1:0] line_q, line_d, last_line;
   logic [7:0]        px_lo_q;
   logic              pclk_q, vsync_q, href_q, done_q, busy_q;
   logic [7:0]        data_q;
   logic              frame_end, href_d;
   logic [15:0]       px_src;

   always_comb begin
      case (state_q)
         ST_VSYNC:  last_line = LINE_W'(VSYNC_LINES - 1);
         ST_VFRONT: last_line = LINE_W'(V_FRONT - 1);
         ST_ACTIVE: last_line = LINE_W'(V_ACTIVE - 1);
         default:   last_line = LINE_W'(V_BACK - 1);
      endcase
   end

   // Position of the next PCLK period: byte wraps into line, line wraps into state.
   always_comb begin
      state_d   = state_q;
      byte_d    = byte_q + 1'b1;
      line_d    = line_q;
      frame_end = 1'b0;
      if (byte_q == LAST_BYTE) begin
         byte_d = '0;
         if (line_q == last_line) begin
            line_d = '0;
            case (state_q)
               ST_VSYNC:  state_d = ST_VFRONT;
               ST_VFRONT: state_d = ST_ACTIVE;
               ST_ACTIVE: state_d = ST_VBACK;
               ST_VBACK: begin
                  frame_end = 1'b1;
                  state_d   = en ? ST_VSYNC : ST_IDLE;
               end
               default:   state_d = ST_IDLE;
            endcase
         end else begin
            line_d = line_q + 1'b1;
         end
      end
      href_d = (state_d == ST_ACTIVE) && (byte_d < HREF_BYTES);
   end

`ifdef COLORBAR_EN
   logic [BYTE_W-2:0] x_d;
   logic              unused_px_color;

   assign x_d             = byte_d[BYTE_W-1:1];
   assign unused_px_color = ^px_color;

   cam_colorbar_rom #(
      .H_ACTIVE (H_ACTIVE),
      .X_W      (BYTE_W - 1)
   ) u_colorbar_rom (
      .x_i   (x_d),
      .rgb_o (px_src)
   );
`else
   assign px_src = px_color;
`endif

   // Entering VSYNC from IDLE counts as the first PCLK fall; every later update waits for pclk 1->0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         byte_q  <= '0;
         line_q  <= '0;
         px_lo_q <= '0;
         pclk_q  <= 1'b0;
         vsync_q <= 1'b0;
         href_q  <= 1'b0;
         data_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else if (state_q == ST_IDLE) begin
         pclk_q <= 1'b0;
         done_q <= 1'b0;
         byte_q <= '0;
         line_q <= '0;
         if (en) begin
            state_q <= ST_VSYNC;
            vsync_q <= 1'b1;
            busy_q  <= 1'b1;
         end
      end else begin
         pclk_q <= ~pclk_q;
         done_q <= 1'b0;
         if (pclk_q) begin
            state_q <= state_d;
            byte_q  <= byte_d;
            line_q  <= line_d;
            vsync_q <= (state_d == ST_VSYNC);
            href_q  <= href_d;
            done_q  <= frame_end;
            busy_q  <= (state_d != ST_IDLE);
            if (href_d && !byte_d[0]) begin
               px_lo_q <= px_src[7:0];
               data_q  <= px_src[15:8];
            end else if (href_d) begin
               data_q  <= px_lo_q;
            end else begin
               data_q  <= '0;
            end
         end
      end
   end

   assign cam_pclk    = pclk_q;
   assign cam_vsync   = vsync_q;
   assign cam_href    = href_q;
   assign cam_px_data = data_q;
   assign frame_done  = done_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_cam_ov7670_tx.sv
// Self-checking bench for cam_ov7670_tx using reduced frame timing and a
// time-index reference model of the camera waveform.
module tb_cam_ov7670_tx;

   localparam int HA = 16;
   localparam int HB = 6;
   localparam int VS = 2;
   localparam int VF = 2;
   localparam int VA = 3;
   localparam int VB = 2;
   localparam int LL = 2 * HA + HB;
   localparam int NL = VS + VF + VA + VB;
   localparam int FR = NL * LL;

   logic        clk = 1'b0;
   logic        rst, en;
   logic [15:0] px_color;
   logic        cam_pclk, cam_vsync, cam_href, frame_done, busy;
   logic [7:0]  cam_px_data;

   int n_checks = 0;
   int n_fail   = 0;
   bit rand_px  = 1'b0;

   cam_ov7670_tx #(
      .H_ACTIVE    (HA),
      .V_ACTIVE    (VA),
      .H_BLANK     (HB),
      .VSYNC_LINES (VS),
      .V_FRONT     (VF),
      .V_BACK      (VB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .px_color    (px_color),
      .cam_pclk    (cam_pclk),
      .cam_vsync   (cam_vsync),
      .cam_href    (cam_href),
      .cam_px_data (cam_px_data),
      .frame_done  (frame_done),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] pixel_of(input int x);
`ifdef COLORBAR_EN
      logic [15:0] bars [8];
      bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
      return bars[x / (HA / 8)];
`else
      return px_color;
`endif
   endfunction

   // Reference model: outputs are a function of clk cycles elapsed since the frame began.
   bit          m_valid = 1'b0;
   bit          m_run   = 1'b0;
   int          m_t     = 0;
   logic [15:0] m_lat   = '0;
   logic        e_pclk, e_vsync, e_href, e_done, e_busy;
   logic [7:0]  e_data;

   always @(posedge clk) begin
      int p, ln, b;
      e_done = 1'b0;
      if (rst) begin
         m_run = 1'b0;
      end else if (!m_run) begin
         if (en) begin
            m_run = 1'b1;
            m_t   = 0;
         end
      end else begin
         m_t++;
         if (m_t == 2 * FR) begin
            e_done = 1'b1;
            if (en) m_t = 0;
            else    m_run = 1'b0;
         end
      end
      if (m_run) begin
         p       = m_t / 2;
         ln      = p / LL;
         b       = p % LL;
         e_pclk  = (m_t % 2) == 1;
         e_vsync = ln < VS;
         e_href  = (ln >= VS + VF) && (ln < VS + VF + VA) && (b < 2 * HA);
         if (e_href && (b % 2 == 0) && (m_t % 2 == 0)) m_lat = pixel_of(b / 2);
         e_data  = !e_href ? 8'h00 : ((b % 2 == 0) ? m_lat[15:8] : m_lat[7:0]);
         e_busy  = 1'b1;
      end else begin
         e_pclk  = 1'b0;
         e_vsync = 1'b0;
         e_href  = 1'b0;
         e_data  = 8'h00;
         e_busy  = 1'b0;
      end
      m_valid = 1'b1;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("pclk",  int'(cam_pclk),    int'(e_pclk));
         chk("vsync", int'(cam_vsync),   int'(e_vsync));
         chk("href",  int'(cam_href),    int'(e_href));
         chk("data",  int'(cam_px_data), int'(e_data));
         chk("done",  int'(frame_done),  int'(e_done));
         chk("busy",  int'(busy),        int'(e_busy));
      end
   end

   always @(negedge clk) if (rand_px) px_color = 16'($urandom);

   function automatic bit active_even_start(input int t);
      int p, ln, b;
      p  = t / 2;
      ln = p / LL;
      b  = p % LL;
      return (t % 2 == 0) && (t < 2 * FR) && (ln >= VS + VF) && (ln < VS + VF + VA)
             && (b % 2 == 0) && (b <= 2 * HA - 4);
   endfunction

   initial begin
      int cnt, np, g;
      bit prev;
      rst      = 1'b1;
      en       = 1'b0;
      px_color = 16'h0000;

      // Reset and idle
      repeat (4) @(negedge clk);
      chk("rst_pclk", int'(cam_pclk), 0);
      chk("rst_busy", int'(busy), 0);
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk("idle_pclk", int'(cam_pclk), 0);
      end

      // Constant red, frame structure
      px_color = 16'hF800;
      en       = 1'b1;
      @(negedge clk);
      cnt = 0;
      while (cam_vsync && cnt < 5000) begin cnt++; @(negedge clk); end
      chk("vsync_len", cnt, 152);
      cnt = 0;
      while (!cam_href && cnt < 5000) begin cnt++; @(negedge clk); end
      chk("vfront_gap", cnt, 152);
      chk("first_byte", int'(cam_px_data), 'hF8);
      np = 0; prev = 1'b0; g = 0;
      while (!frame_done && g < 5000) begin
         if (cam_href && !prev) np++;
         prev = cam_href;
         g++;
         @(negedge clk);
      end
      chk("href_pulses", np, 3);
      chk("frame_done_seen", int'(frame_done), 1);

      // Random pixels; frame period
      rand_px = 1'b1;
      @(negedge clk);
      cnt = 1;
      while (!frame_done && cnt < 5000) begin @(negedge clk); cnt++; end
      chk("frame_period", cnt, 684);

`ifndef COLORBAR_EN
      // Pixel coherence when px_color changes between the two bytes
      rand_px = 1'b0;
      @(negedge clk);
      g = 0;
      while (!(m_run && active_even_start(m_t + 1)) && g < 3000) begin g++; @(negedge clk); end
      chk("coh_found", int'(g < 3000), 1);
      px_color = 16'h1234;
      @(negedge clk);
      chk("coh_b0", int'(cam_px_data), 'h12);
      px_color = 16'hABCD;
      @(negedge clk);
      @(negedge clk);
      chk("coh_b1", int'(cam_px_data), 'h34);
      @(negedge clk);
      @(negedge clk);
      chk("coh_b2", int'(cam_px_data), 'hAB);
      @(negedge clk);
      @(negedge clk);
      chk("coh_b3", int'(cam_px_data), 'hCD);
      rand_px = 1'b1;
`endif

      // Drop en mid-frame in the second active line
      g = 0;
      while (!(m_run && (m_t / 2) / LL == VS + VF + 1) && g < 3000) begin g++; @(negedge clk); end
      en = 1'b0;
      g = 0;
      while (!frame_done && g < 3000) begin g++; @(negedge clk); end
      chk("drop_done_seen", int'(frame_done), 1);
      chk("drop_busy", int'(busy), 0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("drop_idle_pclk", int'(cam_pclk), 0);
         chk("drop_idle_busy", int'(busy), 0);
      end

      // Reset in the middle of a frame
      en = 1'b1;
      repeat ($urandom_range(50, 400)) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_busy",  int'(busy), 0);
      chk("mid_rst_vsync", int'(cam_vsync), 0);
      chk("mid_rst_pclk",  int'(cam_pclk), 0);
      rst = 1'b0;
      en  = 1'b0;
      repeat (10) @(negedge clk);
      chk("final_busy", int'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
